// File: rtl/simon_control.sv
`default_nettype none
// ============================================================================
// Module      : simon_control
// Description : Control unit for the Simon game. Synchronises the player's
//               "enter" button, runs the INPUT / PLAYBACK / REPEAT / DONE game
//               FSM and issues one-cycle command pulses to the Simon datapath.
//               The datapath acts on every clock with a non-zero mode code, so
//               the controller idles on 000 between steps.
// Ports       : clk              - system clock, rising edge
//               rst              - asynchronous reset, active low
//               button           - raw "enter" pushbutton, active high
//               is_legal         - datapath: switch pattern is legal
//               play_gt_count    - datapath: playback index > count
//               repeat_eq_play   - datapath: repeat index == playback index
//               input_eq_pattern - datapath: switches == memory read data
//               select[1:0]      - read-address mux: 00 play, 01 repeat, 10 done
//               mode_leds[2:0]   - datapath command / mode display
//               clrcount         - clear datapath count and pattern LEDs
//               w_en             - memory write enable
//               game_over        - high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module simon_control #(
    parameter int HOLD_CYCLES = 4,   // cycles each pattern is shown (>= 2)
    parameter int HOLD_W      = 24   // hold counter width, 2^HOLD_W > HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       is_legal,
    input  logic       play_gt_count,
    input  logic       repeat_eq_play,
    input  logic       input_eq_pattern,
    output logic [1:0] select,
    output logic [2:0] mode_leds,
    output logic       clrcount,
    output logic       w_en,
    output logic       game_over
);

    typedef enum logic [3:0] {
        ST_INPUT        = 4'd0,
        ST_WRITE        = 4'd1,  // INPUT exit cycle: memory write, still mode 001
        ST_PLAY_STEP    = 4'd2,
        ST_PLAY_HOLD    = 4'd3,
        ST_REPEAT_WAIT  = 4'd4,
        ST_REPEAT_STEP  = 4'd5,
        ST_REPEAT_CHECK = 4'd6,
        ST_DONE_STEP    = 4'd7,
        ST_DONE_HOLD    = 4'd8
    } state_t;

    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_MODE_IDLE   = 3'b000;
    localparam logic [2:0] c_MODE_INPUT  = 3'b001;
    localparam logic [2:0] c_MODE_PLAY   = 3'b010;
    localparam logic [2:0] c_MODE_REPEAT = 3'b100;
    localparam logic [2:0] c_MODE_DONE   = 3'b111;

    localparam logic [1:0] c_SEL_PLAY    = 2'b00;
    localparam logic [1:0] c_SEL_REPEAT  = 2'b01;
    localparam logic [1:0] c_SEL_DONE    = 2'b10;

    state_t            r_state;
    state_t            w_state_next;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;
    logic              r_btn_pulse;
    logic              r_clr_pending;

    logic [1:0]        w_select_next;
    logic [2:0]        w_mode_next;
    logic              w_wen_next;
    logic              w_game_over_next;

    // Two-flop synchroniser, then a registered rising-edge detector. The pulse
    // lands three clocks after the press and lasts one cycle however long the
    // button is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_btn_pulse <= 1'b0;
        end else begin
            r_sync1     <= button;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_btn_pulse <= r_sync2 & ~r_sync3;
        end
    end

    // Next-state logic plus decode of the outputs for the state being entered,
    // so every output comes straight from a flop and tracks r_state exactly.
    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = r_hold;
        w_select_next    = c_SEL_PLAY;
        w_mode_next      = c_MODE_INPUT;
        w_wen_next       = 1'b0;
        w_game_over_next = 1'b0;

        case (r_state)
            ST_INPUT: begin
                if (r_btn_pulse && is_legal) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_next = ST_PLAY_STEP;
            end
            ST_PLAY_STEP: begin
                w_state_next = ST_PLAY_HOLD;
                w_hold_next  = c_HOLD_LOAD;
            end
            ST_PLAY_HOLD: begin
                // Leaving when the count steps from 1 to 0 gives the step
                // cycle plus HOLD_CYCLES-1 idle cycles per pattern.
                if (r_hold <= c_HOLD_ONE) begin
                    w_hold_next  = '0;
                    w_state_next = play_gt_count ? ST_REPEAT_WAIT : ST_PLAY_STEP;
                end else begin
                    w_hold_next  = r_hold - c_HOLD_ONE;
                end
            end
            ST_REPEAT_WAIT: begin
                if (r_btn_pulse) begin
                    w_state_next = input_eq_pattern ? ST_REPEAT_STEP : ST_DONE_STEP;
                end
            end
            ST_REPEAT_STEP: begin
                w_state_next = ST_REPEAT_CHECK;
            end
            ST_REPEAT_CHECK: begin
                // Datapath has absorbed the repeat step by now.
                w_state_next = repeat_eq_play ? ST_INPUT : ST_REPEAT_WAIT;
            end
            ST_DONE_STEP: begin
                w_state_next = ST_DONE_HOLD;
                w_hold_next  = c_HOLD_LOAD;
            end
            ST_DONE_HOLD: begin
                if (r_hold <= c_HOLD_ONE) begin
                    w_hold_next  = '0;
                    w_state_next = ST_DONE_STEP;
                end else begin
                    w_hold_next  = r_hold - c_HOLD_ONE;
                end
            end
            default: begin
                w_state_next = ST_INPUT;
                w_hold_next  = '0;
            end
        endcase

        case (w_state_next)
            ST_WRITE:        w_wen_next = 1'b1;
            ST_PLAY_STEP:    w_mode_next = c_MODE_PLAY;
            ST_PLAY_HOLD:    w_mode_next = c_MODE_IDLE;
            ST_REPEAT_WAIT,
            ST_REPEAT_CHECK: begin
                w_select_next = c_SEL_REPEAT;
                w_mode_next   = c_MODE_IDLE;
            end
            ST_REPEAT_STEP: begin
                w_select_next = c_SEL_REPEAT;
                w_mode_next   = c_MODE_REPEAT;
            end
            ST_DONE_STEP: begin
                w_select_next    = c_SEL_DONE;
                w_mode_next      = c_MODE_DONE;
                w_game_over_next = 1'b1;
            end
            ST_DONE_HOLD: begin
                w_select_next    = c_SEL_DONE;
                w_mode_next      = c_MODE_IDLE;
                w_game_over_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_INPUT;
            r_hold        <= '0;
            r_clr_pending <= 1'b1;
            select        <= c_SEL_PLAY;
            mode_leds     <= c_MODE_INPUT;
            w_en          <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hold        <= w_hold_next;
            r_clr_pending <= 1'b0;
            select        <= w_select_next;
            mode_leds     <= w_mode_next;
            w_en          <= w_wen_next;
            game_over     <= w_game_over_next;
        end
    end

    // Clear request covers the reset period and the first edge after release.
    assign clrcount = r_clr_pending;

endmodule
`default_nettype wire

// File: tb/tb_simon_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_control
// Description : Scoreboard bench for simon_control. The stimulus process
//               pushes each expected output change (vector + cycle stamp);
//               the monitor pops and compares whenever the outputs change.
//               Output vector = {select, mode_leds, clrcount, w_en, game_over}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       is_legal;
    logic       play_gt_count;
    logic       repeat_eq_play;
    logic       input_eq_pattern;
    logic [1:0] select;
    logic [2:0] mode_leds;
    logic       clrcount;
    logic       w_en;
    logic       game_over;

    simon_control #(.HOLD_CYCLES(4), .HOLD_W(24)) dut (
        .clk              (clk),
        .rst              (rst),
        .button           (button),
        .is_legal         (is_legal),
        .play_gt_count    (play_gt_count),
        .repeat_eq_play   (repeat_eq_play),
        .input_eq_pattern (input_eq_pattern),
        .select           (select),
        .mode_leds        (mode_leds),
        .clrcount         (clrcount),
        .w_en             (w_en),
        .game_over        (game_over)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] c_V_RST = {2'b00, 3'b001, 1'b1, 1'b0, 1'b0};
    localparam logic [7:0] c_V_IN  = {2'b00, 3'b001, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] c_V_WR  = {2'b00, 3'b001, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] c_V_PS  = {2'b00, 3'b010, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] c_V_PH  = {2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] c_V_RW  = {2'b01, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] c_V_RS  = {2'b01, 3'b100, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] c_V_DS  = {2'b10, 3'b111, 1'b0, 1'b0, 1'b1};
    localparam logic [7:0] c_V_DH  = {2'b10, 3'b000, 1'b0, 1'b0, 1'b1};

    typedef struct {
        logic [7:0] vec;
        int         cyc;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc     = 0;
    int         n_cmp   = 0;
    int         n_fail  = 0;
    logic [7:0] last    = 'x;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [7:0] v, input int c, input string tag);
        exp_t e;
        e.vec = v;
        e.cyc = c;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] out_vec();
        return {select, mode_leds, clrcount, w_en, game_over};
    endfunction

    // Monitor: every observed output change consumes one expected event.
    always @(negedge clk) begin
        logic [7:0] v;
        exp_t       e;
        v = out_vec();
        if (v !== last) begin
            last = v;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got %b at cycle %0d, required no change", v, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.vec !== v || e.cyc != cyc)
                    begin
                        n_fail++;
                        $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                 e.tag, v, cyc, e.vec, e.cyc);
                    end
            end
        end
    end

    // Immediate check used while reset is asserted between clock edges.
    task automatic check_now(input string tag, input logic [7:0] want);
        logic [7:0] v;
        v = out_vec();
        n_cmp++;
        if (v !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", tag, v, want);
        end
    endtask

    initial begin
        int t;
        int t_end;
        rst              = 1'b0;
        button           = 1'b0;
        is_legal         = 1'b0;
        play_gt_count    = 1'b0;
        repeat_eq_play   = 1'b0;
        input_eq_pattern = 1'b0;

        // Reset release: clrcount drops on the first edge after release.
        push(c_V_RST, 1, "reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push(c_V_IN, cyc + 1, "reset_release");

        // Illegal entry: no activity at all for 20+ cycles.
        repeat (2) @(negedge clk);
        button = 1'b1;
        repeat (3) @(negedge clk);
        button = 1'b0;
        repeat (20) @(negedge clk);

        // Legal entry with a long hold, then three playback steps.
        t = cyc;
        is_legal = 1'b1;
        button   = 1'b1;
        push(c_V_WR, t + 4,  "write_pulse");
        push(c_V_PS, t + 5,  "play_step0");
        push(c_V_PH, t + 6,  "play_hold0");
        push(c_V_PS, t + 9,  "play_step1");
        push(c_V_PH, t + 10, "play_hold1");
        push(c_V_PS, t + 13, "play_step2");
        push(c_V_PH, t + 14, "play_hold2");
        push(c_V_RW, t + 17, "repeat_wait");
        repeat (6) @(negedge clk);
        button   = 1'b0;
        is_legal = 1'b0;
        while (cyc < t + 15) @(negedge clk);
        play_gt_count = 1'b1;
        while (cyc < t + 20) @(negedge clk);

        // Correct repeat, not yet at the playback index: back to REPEAT_WAIT.
        t = cyc;
        input_eq_pattern = 1'b1;
        repeat_eq_play   = 1'b0;
        button           = 1'b1;
        push(c_V_RS, t + 4, "repeat_step_a");
        push(c_V_RW, t + 5, "repeat_check_a");
        repeat (2) @(negedge clk);
        button = 1'b0;
        repeat (8) @(negedge clk);

        // Correct repeat reaching the playback index: back to INPUT.
        t = cyc;
        repeat_eq_play = 1'b1;
        button         = 1'b1;
        push(c_V_RS, t + 4, "repeat_step_b");
        push(c_V_RW, t + 5, "repeat_check_b");
        push(c_V_IN, t + 6, "repeat_to_input");
        repeat (2) @(negedge clk);
        button = 1'b0;
        repeat (8) @(negedge clk);

        // Single-step playback straight into REPEAT_WAIT.
        t = cyc;
        is_legal = 1'b1;
        button   = 1'b1;
        push(c_V_WR, t + 4, "write_pulse2");
        push(c_V_PS, t + 5, "play_step_single");
        push(c_V_PH, t + 6, "play_hold_single");
        push(c_V_RW, t + 9, "repeat_wait2");
        repeat (2) @(negedge clk);
        button = 1'b0;
        repeat (10) @(negedge clk);

        // Wrong repeat: DONE loops with a 4-cycle cadence, presses ignored.
        t = cyc;
        t_end = t + 110;
        input_eq_pattern = 1'b0;
        button           = 1'b1;
        for (int k = 0; t + 4 + 4 * k <= t_end; k++) begin
            push(c_V_DS, t + 4 + 4 * k, "done_step");
            if (t + 5 + 4 * k <= t_end) push(c_V_DH, t + 5 + 4 * k, "done_hold");
        end
        repeat (3) @(negedge clk);
        button = 1'b0;
        for (int j = 0; j < 9; j++) begin
            repeat (7) @(negedge clk);
            input_eq_pattern = j[0];
            button = 1'b1;
            repeat (3) @(negedge clk);
            button = 1'b0;
        end
        while (cyc < t_end) @(negedge clk);

        // Reset out of DONE, asserted between edges.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_now("async_reset_done", c_V_RST);
        push(c_V_RST, cyc, "reset_from_done");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push(c_V_IN, cyc + 1, "release_after_done");
        repeat (2) @(negedge clk);

        // New game; reset lands mid PLAY_HOLD with no write following.
        t = cyc;
        is_legal         = 1'b1;
        play_gt_count    = 1'b0;
        input_eq_pattern = 1'b0;
        button           = 1'b1;
        push(c_V_WR, t + 4, "write_pulse3");
        push(c_V_PS, t + 5, "play_step3");
        push(c_V_PH, t + 6, "play_hold3");
        repeat (2) @(negedge clk);
        button = 1'b0;
        while (cyc < t + 7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_now("async_reset_play", c_V_RST);
        push(c_V_RST, cyc, "reset_from_play");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push(c_V_IN, cyc + 1, "release_after_play");
        repeat (12) @(negedge clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d unobserved, required 0 (next %s at cycle %0d)",
                     exp_q.size(), exp_q[0].tag, exp_q[0].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
